// File: rtl/set_check.sv
// set_check: validity checker for packed SETS x WIDTH shift-lane control words.
// Each lane word is {fill, amount[WIDTH-3:0], direction}. Enabled lanes are
// flagged illegal when the fill bit is set with a zero amount, or when the
// amount reaches the lane width. Results appear one cycle after valid_in.
// Optional build macro: SET_CHECK_STICKY_EN. When it is defined, set_err
// accumulates lane errors until reset or clear.
module set_check #(
  parameter int SETS     = 2,
  parameter int WIDTH    = 4,
  parameter int MIN_SETS = 2,
  parameter int MAX_SETS = 16,
  parameter int CNT_W    = 8,
  localparam int FW      = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [SETS-1:0]       lane_en,
  input  logic [SETS*WIDTH-1:0] shift_packed,
  input  logic                  clear,
  output logic                  valid_out,
  output logic [SETS-1:0]       set_err,
  output logic                  err_any,
  output logic [FW-1:0]         first_err,
  output logic                  no_lane_err,
  output logic [CNT_W-1:0]      err_count
);

  localparam int AMT_W = WIDTH - 2;

  // Reject lane geometries the shift arrays cannot be built with
  generate
    if (SETS < MIN_SETS || SETS > MAX_SETS) begin : gSetsBad
      $error("SETS out of range");
    end
    if (WIDTH < 3) begin : gWidthBad
      $error("WIDTH must be at least 3");
    end
  endgenerate

  logic [SETS-1:0]  laneErr;
  logic [SETS-1:0]  unusedDir;
  logic [FW-1:0]    firstIdx;
  logic             countEvent;

  logic             validOut_q, validOut_d;
  logic [SETS-1:0]  setErr_q, setErr_d;
  logic [FW-1:0]    firstErr_q, firstErr_d;
  logic             noLane_q, noLane_d;
  logic [CNT_W-1:0] errCount_q, errCount_d;

  // Per-lane legality check and lowest-index error lane
  always_comb begin
    logic [WIDTH-1:0] word;
    logic [AMT_W-1:0] amount;
    logic             fill;
    laneErr   = '0;
    unusedDir = '0;
    firstIdx  = '0;
    word      = '0;
    amount    = '0;
    fill      = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      word         = shift_packed[i*WIDTH +: WIDTH];
      amount       = word[WIDTH-2:1];
      fill         = word[WIDTH-1];
      unusedDir[i] = word[0];
      laneErr[i]   = lane_en[i] &&
                     (((amount == '0) && fill) || (32'(amount) >= 32'(WIDTH)));
    end
    for (int i = SETS - 1; i >= 0; i--) begin
      if (laneErr[i]) firstIdx = FW'(i);
    end
  end

  // Next-state for the registered results and the saturating event counter
  always_comb begin
    countEvent = valid_in && ((laneErr != '0) || (lane_en == '0));
    validOut_d = valid_in;
    noLane_d   = valid_in && (lane_en == '0);
    firstErr_d = valid_in ? firstIdx : firstErr_q;
`ifdef SET_CHECK_STICKY_EN
    setErr_d   = clear ? '0 : (setErr_q | (valid_in ? laneErr : '0));
`else
    setErr_d   = valid_in ? laneErr : '0;
`endif
    errCount_d = errCount_q;
    if (clear) begin
      errCount_d = '0;
    end else if (countEvent && (errCount_q != '1)) begin
      errCount_d = errCount_q + 1'b1;
    end
  end

  // Result registers; asynchronous reset discards any in-flight word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validOut_q <= 1'b0;
      setErr_q   <= '0;
      firstErr_q <= '0;
      noLane_q   <= 1'b0;
      errCount_q <= '0;
    end else begin
      validOut_q <= validOut_d;
      setErr_q   <= setErr_d;
      firstErr_q <= firstErr_d;
      noLane_q   <= noLane_d;
      errCount_q <= errCount_d;
    end
  end

  // Without the sticky build setErr_q is already zero whenever valid_out is low,
  // so the OR serves both builds
  assign valid_out   = validOut_q;
  assign set_err     = setErr_q;
  assign err_any     = |setErr_q;
  assign first_err   = firstErr_q;
  assign no_lane_err = noLane_q;
  assign err_count   = errCount_q;

endmodule

// File: tb/tb_set_check.sv
// Testbench for set_check: two instances (2x4 lanes with an 8-bit counter,
// 4x5 lanes with a 2-bit counter) checked against a behavioural model.
module tb_set_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       vA, clrA;
  logic [1:0] enA;
  logic [7:0] pkA;
  logic       voA, anyA, nlA;
  logic [1:0] seA;
  logic [0:0] feA;
  logic [7:0] cntA;

  logic        vB, clrB;
  logic [3:0]  enB;
  logic [19:0] pkB;
  logic        voB, anyB, nlB;
  logic [3:0]  seB;
  logic [1:0]  feB;
  logic [1:0]  cntB;

  logic       eVoA, eAnyA, eNlA;
  logic [1:0] eSeA;
  int         eFeA, eCntA;
  logic       eVoB, eAnyB, eNlB;
  logic [3:0] eSeB;
  int         eFeB, eCntB;

  int tests  = 0;
  int failed = 0;

  set_check #(.SETS(2), .WIDTH(4), .CNT_W(8)) dutA (
    .clk(clk), .rst_n(rst_n), .valid_in(vA), .lane_en(enA), .shift_packed(pkA),
    .clear(clrA), .valid_out(voA), .set_err(seA), .err_any(anyA),
    .first_err(feA), .no_lane_err(nlA), .err_count(cntA)
  );

  set_check #(.SETS(4), .WIDTH(5), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .valid_in(vB), .lane_en(enB), .shift_packed(pkB),
    .clear(clrB), .valid_out(voB), .set_err(seB), .err_any(anyB),
    .first_err(feB), .no_lane_err(nlB), .err_count(cntB)
  );

  // Lane rules straight from the word format: {fill, amount, direction}
  function automatic void evalWord(input int sets, input int width, input logic [15:0] en,
                                   input logic [79:0] pk, output logic [15:0] errs,
                                   output int first);
    errs  = '0;
    first = 0;
    for (int i = sets - 1; i >= 0; i--) begin
      logic [79:0] sh;
      int word, amt, fill;
      sh   = pk >> (i * width);
      word = int'(sh[15:0]) & ((1 << width) - 1);
      amt  = (word >> 1) % (1 << (width - 2));
      fill = (word >> (width - 1)) & 1;
      if (en[i] && ((amt == 0 && fill == 1) || amt >= width)) begin
        errs[i] = 1'b1;
        first   = i;
      end
    end
  endfunction

  // Clear the expected state as a reset does
  task automatic modelReset();
    eVoA = 0; eAnyA = 0; eNlA = 0; eSeA = '0; eFeA = 0; eCntA = 0;
    eVoB = 0; eAnyB = 0; eNlB = 0; eSeB = '0; eFeB = 0; eCntB = 0;
  endtask

  // Advance the expected state by one clock using the inputs being applied
  task automatic modelUpdate();
    logic [15:0] errs;
    int first;
    evalWord(2, 4, 16'(enA), 80'(pkA), errs, first);
    eVoA = vA;
`ifdef SET_CHECK_STICKY_EN
    eSeA = clrA ? 2'b00 : (eSeA | (vA ? errs[1:0] : 2'b00));
`else
    eSeA = vA ? errs[1:0] : 2'b00;
`endif
    eAnyA = |eSeA;
    eNlA  = vA && (enA == 0);
    if (vA) eFeA = first;
    if (clrA) eCntA = 0;
    else if (vA && (errs != 0 || enA == 0) && eCntA < 255) eCntA++;

    evalWord(4, 5, 16'(enB), 80'(pkB), errs, first);
    eVoB = vB;
`ifdef SET_CHECK_STICKY_EN
    eSeB = clrB ? 4'b0 : (eSeB | (vB ? errs[3:0] : 4'b0));
`else
    eSeB = vB ? errs[3:0] : 4'b0;
`endif
    eAnyB = |eSeB;
    eNlB  = vB && (enB == 0);
    if (vB) eFeB = first;
    if (clrB) eCntB = 0;
    else if (vB && (errs != 0 || enB == 0) && eCntB < 3) eCntB++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    check("A.valid_out", 32'(voA), 32'(eVoA));
    check("A.set_err", 32'(seA), 32'(eSeA));
    check("A.err_any", 32'(anyA), 32'(eAnyA));
    check("A.first_err", 32'(feA), 32'(eFeA));
    check("A.no_lane_err", 32'(nlA), 32'(eNlA));
    check("A.err_count", 32'(cntA), 32'(eCntA));
    check("B.valid_out", 32'(voB), 32'(eVoB));
    check("B.set_err", 32'(seB), 32'(eSeB));
    check("B.err_any", 32'(anyB), 32'(eAnyB));
    check("B.first_err", 32'(feB), 32'(eFeB));
    check("B.no_lane_err", 32'(nlB), 32'(eNlB));
    check("B.err_count", 32'(cntB), 32'(eCntB));
  endtask

  // Drive one word into each instance, clock it, then compare one step later
  task automatic applyStimulus(input logic va, input logic [1:0] ena, input logic [7:0] pka,
                               input logic ca, input logic vb, input logic [3:0] enb,
                               input logic [19:0] pkb, input logic cb);
    vA = va; enA = ena; pkA = pka; clrA = ca;
    vB = vb; enB = enb; pkB = pkb; clrB = cb;
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput();
  endtask

  initial begin
    rst_n = 1'b0;
    vA = 0; enA = '0; pkA = '0; clrA = 0;
    vB = 0; enB = '0; pkB = '0; clrB = 0;
    modelReset();
    #12;
    checkOutput();
    rst_n = 1'b1;
    @(negedge clk);

    // Legal word on A; B lane 2 amount 4 (legal), lane 0 amount 5 (illegal)
    applyStimulus(1, 2'b11, 8'h32, 0, 1, 4'b0101, {5'h00, 5'h08, 5'h00, 5'h0A}, 0);
    // Lane 1 fill with zero amount; B lane 3 amount 7 with fill
    applyStimulus(1, 2'b11, 8'h80, 0, 1, 4'b1110, {5'h1E, 5'h00, 5'h02, 5'h00}, 0);
    // Idle cycle: flags drop, first_err and counts hold
    applyStimulus(0, 2'b11, 8'h80, 0, 0, 4'b1111, 20'h0, 0);
    // Same word with lane 1 disabled is clean
    applyStimulus(1, 2'b01, 8'h80, 0, 1, 4'b0001, {5'h1E, 5'h00, 5'h02, 5'h00}, 0);
    // No lanes enabled
    applyStimulus(1, 2'b00, 8'h32, 0, 1, 4'b0000, 20'h0, 0);

    // Saturate B's 2-bit counter, then clear against an error word
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 2'b10, 8'h80, 0, 1, 4'b0001, 20'h0000A, 0);
    applyStimulus(1, 2'b10, 8'h80, 1, 1, 4'b0001, 20'h0000A, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++)
      applyStimulus(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom_range(0, 15) == 0),
                    1'($urandom), 4'($urandom), 20'($urandom),
                    1'($urandom_range(0, 15) == 0));

    // Asynchronous reset between edges with an error word in flight
    applyStimulus(1, 2'b11, 8'h80, 0, 1, 4'b0001, 20'h0000A, 0);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk);
    vA = 0; vB = 0;
    #2;
    rst_n = 1'b1;
    applyStimulus(0, 2'b11, 8'h80, 0, 0, 4'b0001, 20'h0000A, 0);
    applyStimulus(1, 2'b11, 8'h32, 0, 1, 4'b1111, 20'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
